vram_arbiter: RTL and testbench
===============================

VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter HBITS, default 7, horizontal pixel address width (128 columns).
REQ-002 SHALL have parameter VBITS, default 6, vertical pixel address width (64 rows).
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive video grants while cpu_req pending; legal range 1..15.
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port cpu_req  in  1  CPU pixel operation request, held until cpu_ack.
REQ-007 SHALL have ports cpu_hpos in HBITS, cpu_vpos in VBITS, cpu_pixel in 2: target pixel and data.
REQ-008 SHALL have port cpu_xor  in  1  1 = XOR draw (read-modify-write), 0 = plain write.
REQ-009 SHALL have port cpu_ack  out  1  one-cycle pulse, CPU operation complete.
REQ-010 SHALL have ports cpu_collision out 1 (sticky XOR-erase flag) and cpu_collision_clr in 1.
REQ-011 SHALL have ports vid_req in 1, vid_hpos in HBITS, vid_vpos in VBITS: scanout read request.
REQ-012 SHALL have ports vid_pixel out 2 (read data) and vid_valid out 1 (one-cycle pulse, vid_pixel valid).
REQ-013 SHALL have ports mem_addr out HBITS+VBITS, mem_din out 2, mem_dout in 2, mem_we out 1: single-port sync VRAM, read data valid one cycle after address.

Function
REQ-014 SHALL use FSM states IDLE, VID_ADDR, VID_DATA, CPU_ADDR, CPU_DATA, CPU_WRITE.
REQ-015 mem_addr SHALL equal {vpos,hpos} of the granted requester, latched on grant; mem_addr/mem_din driven from registers only.
REQ-016 IDLE grant: only vid_req -> VID_ADDR; only cpu_req -> CPU_ADDR if XOR else CPU_WRITE; both -> video unless starve counter == STARVE_LIMIT, then CPU.
REQ-017 Starve counter SHALL increment on each video grant while cpu_req high, saturate at STARVE_LIMIT, clear on CPU grant or when cpu_req low.
REQ-018 Video read: IDLE accept at T -> VID_ADDR T+1 -> VID_DATA T+2 (capture mem_dout) -> IDLE T+3 with vid_valid=1 and vid_pixel = stored pixel.
REQ-019 Plain write: accept at T -> CPU_WRITE T+1 (mem_we=1, mem_din=cpu_pixel) -> IDLE T+2 with cpu_ack=1.
REQ-020 XOR write: accept T -> CPU_ADDR T+1 -> CPU_DATA T+2 (capture old) -> CPU_WRITE T+3 (mem_din = old ^ cpu_pixel) -> IDLE T+4 with cpu_ack=1.
REQ-021 mem_we SHALL be 1 only in CPU_WRITE; exactly one write per CPU operation.
REQ-022 cpu_collision SHALL set in CPU_WRITE of an XOR op when (old & cpu_pixel) != 0; clears on cpu_collision_clr; set wins when simultaneous.
REQ-023 In an IDLE cycle where cpu_ack (vid_valid) is high, cpu_req (vid_req) SHALL be ignored, so a held request is not re-granted.
REQ-024 Request inputs SHALL be sampled only in IDLE; changes during an operation have no effect on it.
REQ-025 vid_pixel SHALL hold its value until the next vid_valid.

Reset
REQ-026 rst_n low at a rising edge SHALL force IDLE, starve counter 0, cpu_ack 0, vid_valid 0, vid_pixel 0, cpu_collision 0, mem_we 0, mem_addr 0, mem_din 0.
REQ-027 Reset mid-operation SHALL abandon it with no ack/valid and no further write; a write in the same cycle as reset is suppressed.

Configuration
REQ-028 Macro VRAM_COLLISION_EN defined: XOR path (CPU_ADDR, CPU_DATA) and cpu_collision implemented per REQ-020/022.
REQ-029 VRAM_COLLISION_EN undefined: cpu_xor ignored, all CPU ops plain writes (REQ-019), cpu_collision constant 0, cpu_collision_clr ignored.

Verification
REQ-030 Reset, then vid_req at (5,3) with VRAM[3*128+5]=2 -> mem_addr=0x185, vid_valid on 3rd cycle after accept, vid_pixel=2.
REQ-031 cpu_req plain, (127,63), pixel 3 -> one mem_we at addr 0x1FFF din 3, cpu_ack 2 cycles after accept.
REQ-032 XOR pixel 3 onto stored 3 (COLLISION_EN) -> write din 0, cpu_collision=1; then cpu_collision_clr -> 0; pixel 3 onto stored 0 -> din 3, flag stays 0.
REQ-033 vid_req and cpu_req held continuously, STARVE_LIMIT=4 -> grant order V,V,V,V,C repeating; CPU never waits more than 4 video ops.
REQ-034 rst_n low during CPU_DATA of XOR op -> no mem_we, no cpu_ack, IDLE next cycle, all outputs at reset values.
REQ-035 Build without VRAM_COLLISION_EN, cpu_xor=1 pixel 1 onto stored 1 -> plain write din 1, ack 2 cycles after accept, cpu_collision stays 0.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between a video scanout reader
// and a CPU pixel writer (plain write or XOR read-modify-write).
//
// Ports:
//   clk, rst_n                  sole clock; synchronous active-low reset
//   cpu_req/cpu_hpos/cpu_vpos   CPU request, target pixel, pixel data, XOR select;
//   cpu_pixel/cpu_xor           the request is held by the CPU until cpu_ack
//   cpu_ack                     one-cycle pulse, CPU operation complete
//   cpu_collision(_clr)         sticky XOR-erase flag and its clear
//   vid_req/vid_hpos/vid_vpos   scanout read request
//   vid_pixel/vid_valid         read data (held) and its one-cycle valid pulse
//   mem_addr/mem_din/mem_we     VRAM port; mem_dout returns read data one cycle after address
//
// Optional feature: define VRAM_COLLISION_EN for the XOR read-modify-write path and the
// collision flag. Without it cpu_xor is ignored and every CPU op is a plain write.
module vram_arbiter #(
  parameter int unsigned HBITS        = 7,
  parameter int unsigned VBITS        = 6,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic [HBITS-1:0]       cpu_hpos,
  input  logic [VBITS-1:0]       cpu_vpos,
  input  logic [1:0]             cpu_pixel,
  input  logic                   cpu_xor,
  output logic                   cpu_ack,
  output logic                   cpu_collision,
  input  logic                   cpu_collision_clr,
  input  logic                   vid_req,
  input  logic [HBITS-1:0]       vid_hpos,
  input  logic [VBITS-1:0]       vid_vpos,
  output logic [1:0]             vid_pixel,
  output logic                   vid_valid,
  output logic [HBITS+VBITS-1:0] mem_addr,
  output logic [1:0]             mem_din,
  input  logic [1:0]             mem_dout,
  output logic                   mem_we
);

  localparam int unsigned AW        = HBITS + VBITS;
  localparam logic [3:0]  StarveMax = 4'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    StIdle, StVidAddr, StVidData, StCpuAddr, StCpuData, StCpuWrite
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]    din_q, din_d;
  logic [1:0]    pix_q, pix_d;
  logic          ack_q, ack_d;
  logic          valid_q, valid_d;
`ifdef VRAM_COLLISION_EN
  logic          xor_q, xor_d;
  logic          hit_q, hit_d;
  logic          coll_q, coll_d;
`else
  logic          unused_inputs;
  assign unused_inputs = cpu_xor ^ cpu_collision_clr;
`endif

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    din_d    = din_q;
    pix_d    = pix_q;
    ack_d    = 1'b0;
    valid_d  = 1'b0;
`ifdef VRAM_COLLISION_EN
    xor_d    = xor_q;
    hit_d    = hit_q;
    coll_d   = coll_q;
    if (cpu_collision_clr) coll_d = 1'b0;
`endif
    if (!cpu_req) starve_d = 4'd0;

    unique case (state_q)
      StIdle: begin
        // A completion cycle (ack or valid high) grants nobody: the finished requester is
        // still holding its request, and letting the other side win here would bypass the
        // starve counter and break the V..V,C rotation.
        if (!ack_q && !valid_q) begin
          if (cpu_req && (!vid_req || starve_q == StarveMax)) begin
            starve_d = 4'd0;
            addr_d   = {cpu_vpos, cpu_hpos};
            din_d    = cpu_pixel;
`ifdef VRAM_COLLISION_EN
            xor_d    = cpu_xor;
            state_d  = cpu_xor ? StCpuAddr : StCpuWrite;
`else
            state_d  = StCpuWrite;
`endif
          end else if (vid_req) begin
            addr_d  = {vid_vpos, vid_hpos};
            state_d = StVidAddr;
            if (cpu_req && starve_q != StarveMax) starve_d = starve_q + 4'd1;
          end
        end
      end
      StVidAddr: state_d = StVidData;
      StVidData: begin
        pix_d   = mem_dout;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      StCpuAddr: state_d = StCpuData;
      StCpuData: begin
`ifdef VRAM_COLLISION_EN
        // din_q still holds the CPU pixel here; replace it with the merged value.
        hit_d   = |(mem_dout & din_q);
        din_d   = mem_dout ^ din_q;
        state_d = StCpuWrite;
`else
        state_d = StIdle;
`endif
      end
      StCpuWrite: begin
        ack_d   = 1'b1;
        state_d = StIdle;
`ifdef VRAM_COLLISION_EN
        if (xor_q && hit_q) coll_d = 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      starve_q <= 4'd0;
      addr_q   <= '0;
      din_q    <= 2'd0;
      pix_q    <= 2'd0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
`ifdef VRAM_COLLISION_EN
      xor_q    <= 1'b0;
      hit_q    <= 1'b0;
      coll_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      pix_q    <= pix_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
`ifdef VRAM_COLLISION_EN
      xor_q    <= xor_d;
      hit_q    <= hit_d;
      coll_q   <= coll_d;
`endif
    end
  end

  // rst_n gates the strobe so a write coinciding with reset never reaches the RAM.
  assign mem_we    = (state_q == StCpuWrite) && rst_n;
  assign mem_addr  = addr_q;
  assign mem_din   = din_q;
  assign cpu_ack   = ack_q;
  assign vid_valid = valid_q;
  assign vid_pixel = pix_q;
`ifdef VRAM_COLLISION_EN
  assign cpu_collision = coll_q;
`else
  assign cpu_collision = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected writes / acks / reads with
// their expected cycle; a negedge monitor pops and compares whenever the DUT shows one.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_xor, cpu_collision_clr, vid_req;
  logic [6:0]  cpu_hpos, vid_hpos;
  logic [5:0]  cpu_vpos, vid_vpos;
  logic [1:0]  cpu_pixel, vid_pixel, mem_din, mem_dout;
  logic        cpu_ack, cpu_collision, vid_valid, mem_we;
  logic [12:0] mem_addr;

  always #5 clk = ~clk;

  vram_arbiter #(.HBITS(7), .VBITS(6), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_hpos(cpu_hpos), .cpu_vpos(cpu_vpos),
    .cpu_pixel(cpu_pixel), .cpu_xor(cpu_xor), .cpu_ack(cpu_ack), .cpu_collision(cpu_collision),
    .cpu_collision_clr(cpu_collision_clr), .vid_req(vid_req), .vid_hpos(vid_hpos),
    .vid_vpos(vid_vpos), .vid_pixel(vid_pixel), .vid_valid(vid_valid), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_we(mem_we)
  );

  // VRAM model: synchronous, read-before-write.
  logic [1:0] vram [0:8191];
  always @(posedge clk) begin
    if (mem_we) vram[mem_addr] <= mem_din;
    mem_dout <= vram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { logic [12:0] addr; logic [1:0] din; int cyc; } wr_t;
  typedef struct { logic [1:0] pix; int cyc; } vid_t;
  wr_t  exp_wr[$];
  vid_t exp_vid[$];
  int   exp_ack[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor
  wr_t  mw;
  vid_t mv;
  int   ma;
  always @(negedge clk) begin
    #1;
    if (mem_we === 1'b1) begin
      if (exp_wr.size() == 0) flag("unexpected_write");
      else begin
        mw = exp_wr.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(mw.addr));
        check("wr_din", 32'(mem_din), 32'(mw.din));
        check("wr_cycle", cyc, mw.cyc);
      end
    end
    if (cpu_ack === 1'b1) begin
      if (exp_ack.size() == 0) flag("unexpected_ack");
      else begin
        ma = exp_ack.pop_front();
        check("ack_cycle", cyc, ma);
      end
    end
    if (vid_valid === 1'b1) begin
      if (exp_vid.size() == 0) flag("unexpected_valid");
      else begin
        mv = exp_vid.pop_front();
        check("vid_pixel", 32'(vid_pixel), 32'(mv.pix));
        check("vid_cycle", cyc, mv.cyc);
      end
    end
  end

  function automatic logic [12:0] pa(input int h, input int v);
    return 13'((v << 7) | h);
  endfunction

  task automatic vid_op(input int h, input int v, input logic [1:0] pix);
    int   t;
    vid_t e;
    @(negedge clk);
    vid_hpos = 7'(h); vid_vpos = 6'(v); vid_req = 1'b1;
    t = cyc;
    e.pix = pix; e.cyc = t + 3;
    exp_vid.push_back(e);
    @(negedge clk);
    check("vid_addr", 32'(mem_addr), 32'(pa(h, v)));
    for (int i = 0; i < 20; i++) begin
      if (vid_valid) break;
      @(negedge clk);
    end
    if (!vid_valid) flag("vid_timeout");
    vid_req = 1'b0;
  endtask

  task automatic cpu_op(input int h, input int v, input logic [1:0] pix, input logic x,
                        input logic [1:0] exp_din, input logic rmw);
    int  t;
    int  lat;
    wr_t e;
    @(negedge clk);
    cpu_hpos = 7'(h); cpu_vpos = 6'(v); cpu_pixel = pix; cpu_xor = x; cpu_req = 1'b1;
    t = cyc;
    lat = rmw ? 3 : 1;
    e.addr = pa(h, v); e.din = exp_din; e.cyc = t + lat;
    exp_wr.push_back(e);
    exp_ack.push_back(t + lat + 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ack) break;
    end
    if (!cpu_ack) flag("ack_timeout");
    cpu_req = 1'b0;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_ack"}, 32'(cpu_ack), 0);
    check({tag, "_valid"}, 32'(vid_valid), 0);
    check({tag, "_vid_pixel"}, 32'(vid_pixel), 0);
    check({tag, "_collision"}, 32'(cpu_collision), 0);
    check({tag, "_we"}, 32'(mem_we), 0);
    check({tag, "_addr"}, 32'(mem_addr), 0);
    check({tag, "_din"}, 32'(mem_din), 0);
  endtask

  logic rmw_en;
  int   t0;

  initial begin
`ifdef VRAM_COLLISION_EN
    rmw_en = 1'b1;
`else
    rmw_en = 1'b0;
`endif
    for (int i = 0; i < 8192; i++) vram[i] = 2'd0;
    vram[13'h185] = 2'd2;
    rst_n = 1'b0; cpu_req = 1'b0; cpu_xor = 1'b0; cpu_collision_clr = 1'b0; vid_req = 1'b0;
    cpu_hpos = '0; cpu_vpos = '0; cpu_pixel = '0; vid_hpos = '0; vid_vpos = '0;
    repeat (3) @(negedge clk);
    check_rst("reset");
    rst_n = 1'b1;

    // Video read at (5,3), stored 2, address 0x185.
    vid_op(5, 3, 2'd2);
    // Plain write corner pixel, then read it back.
    cpu_op(127, 63, 2'd3, 1'b0, 2'd3, 1'b0);
    vid_op(127, 63, 2'd3);

`ifdef VRAM_COLLISION_EN
    cpu_op(10, 20, 2'd3, 1'b0, 2'd3, 1'b0);
    cpu_op(10, 20, 2'd3, 1'b1, 2'd0, 1'b1);
    check("collision_set", 32'(cpu_collision), 1);
    @(negedge clk); cpu_collision_clr = 1'b1;
    @(negedge clk); cpu_collision_clr = 1'b0;
    check("collision_clr", 32'(cpu_collision), 0);
    cpu_op(10, 20, 2'd3, 1'b1, 2'd3, 1'b1);
    check("collision_stays_clear", 32'(cpu_collision), 0);
    vid_op(10, 20, 2'd3);
`else
    cpu_op(1, 1, 2'd1, 1'b0, 2'd1, 1'b0);
    cpu_op(1, 1, 2'd1, 1'b1, 2'd1, 1'b0);
    check("collision_off", 32'(cpu_collision), 0);
    @(negedge clk); cpu_collision_clr = 1'b1;
    @(negedge clk); cpu_collision_clr = 1'b0;
    vid_op(1, 1, 2'd1);
`endif
    check("rmw_flag_consistent", 32'(rmw_en), 32'(rmw_en)); // build marker
    checks--; // marker above is not a real comparison

    // Both requesters held: expect V,V,V,V,C twice.
    @(negedge clk);
    vid_hpos = 7'd5; vid_vpos = 6'd3; vid_req = 1'b1;
    cpu_hpos = 7'd0; cpu_vpos = 6'd0; cpu_pixel = 2'd1; cpu_xor = 1'b0; cpu_req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        wr_t w;
        w.addr = 13'd0; w.din = 2'd1; w.cyc = t0 + 1;
        exp_wr.push_back(w);
        exp_ack.push_back(t0 + 2);
        t0 += 3;
      end else begin
        vid_t r;
        r.pix = 2'd2; r.cyc = t0 + 3;
        exp_vid.push_back(r);
        t0 += 4;
      end
    end
    for (int i = 0; i < 200; i++) begin
      if (cyc >= t0 - 1) break;
      @(negedge clk);
    end
    check("starve_end_cycle", cyc, t0 - 1);
    vid_req = 1'b0; cpu_req = 1'b0;

    // Reset during the write cycle of a plain op: write and ack suppressed.
    @(negedge clk);
    cpu_hpos = 7'd2; cpu_vpos = 6'd2; cpu_pixel = 2'd3; cpu_xor = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check_rst("rst_in_write");
    rst_n = 1'b1;
    vid_op(2, 2, 2'd0);

`ifdef VRAM_COLLISION_EN
    // Reset during CPU_DATA of an XOR op.
    vid_op(5, 3, 2'd2);
    @(negedge clk);
    cpu_hpos = 7'd3; cpu_vpos = 6'd3; cpu_pixel = 2'd2; cpu_xor = 1'b1; cpu_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    check_rst("rst_in_data");
    rst_n = 1'b1;
    vid_op(3, 3, 2'd0);
`endif

    repeat (10) @(negedge clk);
    check("pending_writes", exp_wr.size(), 0);
    check("pending_acks", exp_ack.size(), 0);
    check("pending_reads", exp_vid.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
